// File: rtl/fwd_hazard_unit_pkg.sv
// Shared types and constants for the EX-stage forwarding/hazard unit.
// Entry width is fixed here; the top-level REG_ADDR_W must equal REG_ADDR_W_DEFAULT.
package fwd_hazard_unit_pkg;

  localparam int REG_ADDR_W_DEFAULT = 5;

  typedef enum logic [1:0] {
    FWD_REGFILE = 2'b00,
    FWD_WB      = 2'b01,
    FWD_MEM     = 2'b10
  } fwd_sel_e;

  typedef struct packed {
    logic                          valid;
    logic [REG_ADDR_W_DEFAULT-1:0] src1;
    logic [REG_ADDR_W_DEFAULT-1:0] src2;
    logic [REG_ADDR_W_DEFAULT-1:0] dest;
    logic                          wb_en;
    logic                          mem_read;
  } pipe_entry_t;

  // True when the entry will write a non-zero register equal to src.
  function automatic logic writes_reg(input pipe_entry_t e,
                                      input logic [REG_ADDR_W_DEFAULT-1:0] src);
    return e.valid && e.wb_en && (e.dest != '0) && (e.dest == src);
  endfunction

endpackage

// File: rtl/fwd_hazard_unit_match.sv
// Combinational operand-select for one EX source: MEM beats WB, loads in MEM
// never forward because their data is not available until WB.
module fwd_match
  import fwd_hazard_unit_pkg::*;
(
  input  logic [REG_ADDR_W_DEFAULT-1:0] src_i,
  input  pipe_entry_t                   mem_i,
  input  pipe_entry_t                   wb_i,
  output logic [1:0]                    sel_o
);

  logic mem_hit;
  logic wb_hit;
  logic unused_fields;

  assign mem_hit = writes_reg(mem_i, src_i) && !mem_i.mem_read;
  assign wb_hit  = writes_reg(wb_i, src_i);

  always_comb begin
    sel_o = FWD_REGFILE;
    if (mem_hit) begin
      sel_o = FWD_MEM;
    end else if (wb_hit) begin
      sel_o = FWD_WB;
    end
  end

  assign unused_fields = ^{mem_i.src1, mem_i.src2, wb_i.src1, wb_i.src2, wb_i.mem_read};

endmodule

// File: rtl/fwd_hazard_unit.sv
// Forwarding and load-use hazard unit: shadows EX/MEM/WB destination fields,
// drives the EX operand-mux selects and the fetch-side stall.
module fwd_hazard_unit
  import fwd_hazard_unit_pkg::*;
#(
  parameter int REG_ADDR_W = REG_ADDR_W_DEFAULT,
  parameter int CNT_W      = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  id_valid,
  input  logic [REG_ADDR_W-1:0] id_src1,
  input  logic [REG_ADDR_W-1:0] id_src2,
  input  logic [REG_ADDR_W-1:0] id_dest,
  input  logic                  id_wb_en,
  input  logic                  id_mem_read,
  input  logic                  flush,
  output logic [1:0]            fwd_sel_a,
  output logic [1:0]            fwd_sel_b,
  output logic                  stall,
  output logic [CNT_W-1:0]      stall_count
);

  pipe_entry_t ex_q, mem_q, wb_q;
  pipe_entry_t ex_d, mem_d, wb_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [1:0] sel_a_raw, sel_b_raw;

  // Load in EX whose destination feeds the instruction now in ID.
  assign stall = id_valid && ex_q.valid && ex_q.mem_read && ex_q.wb_en &&
                 (ex_q.dest != '0) &&
                 ((ex_q.dest == id_src1) || (ex_q.dest == id_src2));

  always_comb begin
    ex_d          = '0;
    ex_d.valid    = id_valid && !stall && !flush;
    ex_d.src1     = id_src1;
    ex_d.src2     = id_src2;
    ex_d.dest     = id_dest;
    ex_d.wb_en    = id_wb_en;
    ex_d.mem_read = id_mem_read;

    // Sources are only needed while the instruction sits in EX.
    mem_d      = ex_q;
    mem_d.src1 = '0;
    mem_d.src2 = '0;

    wb_d = mem_q;
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall && !(&stall_cnt_q)) begin
      stall_cnt_d = stall_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ex_q        <= '0;
      mem_q       <= '0;
      wb_q        <= '0;
      stall_cnt_q <= '0;
    end else begin
      ex_q        <= ex_d;
      mem_q       <= mem_d;
      wb_q        <= wb_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  fwd_match u_match_a (
    .src_i (ex_q.src1),
    .mem_i (mem_q),
    .wb_i  (wb_q),
    .sel_o (sel_a_raw)
  );

  fwd_match u_match_b (
    .src_i (ex_q.src2),
    .mem_i (mem_q),
    .wb_i  (wb_q),
    .sel_o (sel_b_raw)
  );

  // A bubble in EX consumes nothing, so it always reads the register file.
  assign fwd_sel_a   = ex_q.valid ? sel_a_raw : FWD_REGFILE;
  assign fwd_sel_b   = ex_q.valid ? sel_b_raw : FWD_REGFILE;
  assign stall_count = stall_cnt_q;

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Directed-vector bench for fwd_hazard_unit; a second instance with a 4-bit
// stall counter shares the stimulus to exercise counter saturation.
module tb_fwd_hazard_unit;

  logic       clk;
  logic       rst;
  logic       id_valid;
  logic [4:0] id_src1, id_src2, id_dest;
  logic       id_wb_en, id_mem_read, flush;

  logic [1:0]  fwd_sel_a, fwd_sel_b;
  logic        stall;
  logic [15:0] stall_count;

  logic [1:0]  sat_sel_a, sat_sel_b;
  logic        sat_stall;
  logic [3:0]  sat_count;

  int n_vec;
  int n_err;
  int exp_stalls;
  logic ex_load;

  fwd_hazard_unit dut (
    .clk         (clk),
    .rst         (rst),
    .id_valid    (id_valid),
    .id_src1     (id_src1),
    .id_src2     (id_src2),
    .id_dest     (id_dest),
    .id_wb_en    (id_wb_en),
    .id_mem_read (id_mem_read),
    .flush       (flush),
    .fwd_sel_a   (fwd_sel_a),
    .fwd_sel_b   (fwd_sel_b),
    .stall       (stall),
    .stall_count (stall_count)
  );

  fwd_hazard_unit #(.CNT_W(4)) dut_sat (
    .clk         (clk),
    .rst         (rst),
    .id_valid    (id_valid),
    .id_src1     (id_src1),
    .id_src2     (id_src2),
    .id_dest     (id_dest),
    .id_wb_en    (id_wb_en),
    .id_mem_read (id_mem_read),
    .flush       (flush),
    .fwd_sel_a   (sat_sel_a),
    .fwd_sel_b   (sat_sel_b),
    .stall       (sat_stall),
    .stall_count (sat_count)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_id(input logic v, input logic [4:0] s1, input logic [4:0] s2,
                          input logic [4:0] d, input logic wb, input logic mr,
                          input logic fl);
    id_valid    = v;
    id_src1     = s1;
    id_src2     = s2;
    id_dest     = d;
    id_wb_en    = wb;
    id_mem_read = mr;
    flush       = fl;
    #1;
  endtask

  task automatic drive_nop();
    drive_id(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    exp_stalls = 0;

    // Reset with a live-looking instruction in ID
    rst = 1'b1;
    drive_id(1'b1, 5'd7, 5'd7, 5'd7, 1'b1, 1'b1, 1'b0);
    tick();
    tick();
    rst = 1'b0;
    check_eq("rst_sel_a", {30'd0, fwd_sel_a}, 32'd0);
    check_eq("rst_sel_b", {30'd0, fwd_sel_b}, 32'd0);
    check_eq("rst_stall", {31'd0, stall}, 32'd0);
    check_eq("rst_count", {16'd0, stall_count}, 32'd0);
    check_eq("rst_count_sat", {28'd0, sat_count}, 32'd0);

    // EX/MEM forward: add r3, then sub r8 <- r3, r4
    drive_id(1'b1, 5'd1, 5'd2, 5'd3, 1'b1, 1'b0, 1'b0);
    tick();
    drive_id(1'b1, 5'd3, 5'd4, 5'd8, 1'b1, 1'b0, 1'b0);
    tick();
    drive_nop();
    check_eq("exmem_sel_a", {30'd0, fwd_sel_a}, 32'd2);
    check_eq("exmem_sel_b", {30'd0, fwd_sel_b}, 32'd0);
    check_eq("exmem_stall", {31'd0, stall}, 32'd0);
    tick();
    check_eq("bubble_sel_a", {30'd0, fwd_sel_a}, 32'd0);

    // Priority: back-to-back writes to r5, consumer src2 = 5
    drive_id(1'b1, 5'd1, 5'd1, 5'd5, 1'b1, 1'b0, 1'b0);
    tick();
    drive_id(1'b1, 5'd2, 5'd2, 5'd5, 1'b1, 1'b0, 1'b0);
    tick();
    drive_id(1'b1, 5'd1, 5'd5, 5'd6, 1'b1, 1'b0, 1'b0);
    tick();
    drive_nop();
    check_eq("prio_mem_sel_b", {30'd0, fwd_sel_b}, 32'd2);
    check_eq("prio_mem_sel_a", {30'd0, fwd_sel_a}, 32'd0);

    // Priority: one independent instruction in between -> WB forward
    drive_id(1'b1, 5'd1, 5'd1, 5'd5, 1'b1, 1'b0, 1'b0);
    tick();
    drive_id(1'b1, 5'd1, 5'd2, 5'd9, 1'b1, 1'b0, 1'b0);
    tick();
    drive_id(1'b1, 5'd1, 5'd5, 5'd6, 1'b1, 1'b0, 1'b0);
    tick();
    drive_nop();
    check_eq("prio_wb_sel_b", {30'd0, fwd_sel_b}, 32'd1);

    // Load-use: lw r7, then consumer src1 = 7
    drive_id(1'b1, 5'd2, 5'd2, 5'd7, 1'b1, 1'b1, 1'b0);
    tick();
    drive_id(1'b1, 5'd7, 5'd1, 5'd10, 1'b1, 1'b0, 1'b0);
    check_eq("lu_stall_on", {31'd0, stall}, 32'd1);
    exp_stalls++;
    tick();
    check_eq("lu_stall_off", {31'd0, stall}, 32'd0);
    check_eq("lu_count", {16'd0, stall_count}, exp_stalls);
    tick();
    drive_nop();
    check_eq("lu_sel_a", {30'd0, fwd_sel_a}, 32'd1);
    check_eq("lu_sel_b", {30'd0, fwd_sel_b}, 32'd0);

    // r0 is never a forwarding source
    drive_id(1'b1, 5'd1, 5'd2, 5'd0, 1'b1, 1'b0, 1'b0);
    tick();
    drive_id(1'b1, 5'd0, 5'd0, 5'd11, 1'b1, 1'b0, 1'b0);
    tick();
    drive_nop();
    check_eq("r0_sel_a", {30'd0, fwd_sel_a}, 32'd0);
    check_eq("r0_sel_b", {30'd0, fwd_sel_b}, 32'd0);

    // r0 is never a stall source
    drive_id(1'b1, 5'd1, 5'd1, 5'd0, 1'b1, 1'b1, 1'b0);
    tick();
    drive_id(1'b1, 5'd0, 5'd0, 5'd12, 1'b1, 1'b0, 1'b0);
    check_eq("r0_stall", {31'd0, stall}, 32'd0);
    tick();

    // Flushed load must not cause a stall
    drive_id(1'b1, 5'd2, 5'd2, 5'd7, 1'b1, 1'b1, 1'b1);
    tick();
    drive_id(1'b1, 5'd7, 5'd3, 5'd13, 1'b1, 1'b0, 1'b0);
    check_eq("flush_load_stall", {31'd0, stall}, 32'd0);
    tick();

    // Flush coincident with a load-use stall
    drive_id(1'b1, 5'd2, 5'd2, 5'd7, 1'b1, 1'b1, 1'b0);
    tick();
    drive_id(1'b1, 5'd7, 5'd3, 5'd13, 1'b1, 1'b0, 1'b1);
    check_eq("flush_stall_on", {31'd0, stall}, 32'd1);
    exp_stalls++;
    tick();
    drive_id(1'b1, 5'd7, 5'd3, 5'd13, 1'b1, 1'b0, 1'b0);
    check_eq("flush_ex_bubble_stall", {31'd0, stall}, 32'd0);
    check_eq("flush_ex_bubble_sel_a", {30'd0, fwd_sel_a}, 32'd0);
    check_eq("flush_count", {16'd0, stall_count}, exp_stalls);
    tick();
    drive_nop();
    check_eq("flush_then_wb_sel_a", {30'd0, fwd_sel_a}, 32'd1);

    // Flushed producer must not forward
    drive_id(1'b1, 5'd1, 5'd1, 5'd3, 1'b1, 1'b0, 1'b1);
    tick();
    drive_id(1'b1, 5'd3, 5'd4, 5'd14, 1'b1, 1'b0, 1'b0);
    tick();
    drive_nop();
    check_eq("flush_prod_sel_a", {30'd0, fwd_sel_a}, 32'd0);

    // Saturation: back-to-back self-dependent loads stall every other cycle
    tick();
    tick();
    tick();
    ex_load = 1'b0;
    drive_id(1'b1, 5'd7, 5'd7, 5'd7, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 40; i++) begin
      check_eq("sat_stall", {31'd0, stall}, {31'd0, ex_load});
      if (ex_load) exp_stalls++;
      tick();
      ex_load = !ex_load;
      check_eq("sat_count16", {16'd0, stall_count}, exp_stalls);
      check_eq("sat_count4", {28'd0, sat_count}, (exp_stalls > 15) ? 32'd15 : exp_stalls);
    end

    // Reset mid-operation discards in-flight producers
    drive_id(1'b1, 5'd1, 5'd1, 5'd3, 1'b1, 1'b0, 1'b0);
    tick();
    rst = 1'b1;
    drive_id(1'b1, 5'd3, 5'd3, 5'd14, 1'b1, 1'b0, 1'b0);
    tick();
    rst = 1'b0;
    check_eq("midrst_count", {16'd0, stall_count}, 32'd0);
    check_eq("midrst_count_sat", {28'd0, sat_count}, 32'd0);
    tick();
    drive_nop();
    check_eq("midrst_sel_a", {30'd0, fwd_sel_a}, 32'd0);
    check_eq("midrst_sel_b", {30'd0, fwd_sel_b}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/fwd_hazard_unit.md
Name: fwd_hazard_unit

Overview:
- Pipeline-tracking forwarding and hazard unit for the 5-stage datapath.
- Keeps a registered shadow of the destination and control fields of the instructions in EX, MEM and WB.
- Drives the 2-bit select of the EX-stage 3-input operand muxes, and raises a load-use stall toward the IF/ID registers.
- Sits directly upstream of the operand muxes and consumes decode-stage register fields.

Parameters:
- REG_ADDR_W, 5, register-file address width.
- CNT_W, 16, width of the saturating stall counter.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- id_valid  input  1  ID holds a real instruction.
- id_src1  input  REG_ADDR_W  ID source register 1.
- id_src2  input  REG_ADDR_W  ID source register 2.
- id_dest  input  REG_ADDR_W  ID destination register.
- id_wb_en  input  1  ID instruction writes the register file.
- id_mem_read  input  1  ID instruction is a load.
- flush  input  1  branch taken; kill the instruction entering EX.
- fwd_sel_a  output  2  EX operand A select: 00 regfile, 01 WB result, 10 MEM ALU result.
- fwd_sel_b  output  2  EX operand B select, same encoding.
- stall  output  1  hold PC and IF/ID; insert a bubble into EX.
- stall_count  output  CNT_W  number of stall cycles since reset, saturating.

Behaviour:
- One clock, clk. Reset is synchronous, active-high, on port rst. rst is sampled on the rising edge of clk.
- State: three entries EX, MEM, WB. Each entry holds valid, src1, src2, dest, wb_en, mem_read. Sources are kept only in EX.
- Reset: all entry valid bits = 0; stall_count = 0. Consequently fwd_sel_a = fwd_sel_b = 00 and stall = 0 in the cycle after reset.
- Advance every cycle, no enable:
  - WB <= MEM.
  - MEM <= EX.
  - EX <= ID fields with valid = id_valid & ~stall & ~flush.
  - When valid = 0, the other captured fields are don't-care but must not affect any output.
- Forwarding is combinational from registered state (zero latency relative to the EX entry):
  - fwd_sel_a = 10 when MEM.valid & MEM.wb_en & MEM.dest != 0 & MEM.dest == EX.src1.
  - Otherwise fwd_sel_a = 01 when the same condition holds for WB.
  - Otherwise fwd_sel_a = 00.
  - MEM has priority over WB (youngest producer wins).
  - fwd_sel_b is identical using EX.src2.
  - When EX.valid = 0, both selects = 00.
  - Encoding 11 is never driven.
- A MEM entry with mem_read = 1 never forwards. Its data is not yet available; the load-use stall guarantees the case never occurs for a valid consumer.
- Stall is combinational: stall = id_valid & EX.valid & EX.mem_read & EX.wb_en & EX.dest != 0 & (EX.dest == id_src1 | EX.dest == id_src2).
  - A single stall cycle resolves the hazard: the load moves to MEM, and the bubble moves into EX.
- Register 0 is never a forwarding or stall source.
- flush and stall in the same cycle: flush wins for the EX entry (bubble inserted), and stall is still asserted to the fetch side.
- stall_count increments each cycle stall = 1; it holds at all-ones on saturation.
- Reset mid-operation: all in-flight entries are discarded the next cycle. No forwarding from pre-reset instructions.

Decomposition:
- Shared package:
  - FWD_REGFILE = 2'b00, FWD_WB = 2'b01, FWD_MEM = 2'b10.
  - Pipeline-entry struct {valid, src1, src2, dest, wb_en, mem_read}.
  - REG_ADDR_W default.
- One natural sub-module: fwd_match. It is combinational; inputs are one source address plus the MEM and WB entries, output is the 2-bit select. It is instantiated twice, once for A and once for B.
- The stall counter stays inline.

Test Plan:
- Reset: assert rst for 2 cycles with id_valid = 1 -> next cycle fwd_sel_a = fwd_sel_b = 00, stall = 0, stall_count = 0.
- EX/MEM forward: issue add r3 (dest 3, wb_en), then sub with src1 = 3, src2 = 4 -> when sub is in EX, fwd_sel_a = 10 and fwd_sel_b = 00.
- Priority: issue writes to r5 in cycles 0 and 1, then a consumer with src2 = 5 -> fwd_sel_b = 10 (MEM beats WB). With one independent instruction in between instead -> fwd_sel_b = 01.
- Load-use: issue lw r7 (mem_read, wb_en), then an instruction with src1 = 7 -> stall = 1 for exactly one cycle and stall_count = 1. Consumer reaches EX with fwd_sel_a = 01.
- r0 and flush:
  - Write to r0, then a consumer with src1 = 0 -> fwd_sel_a = 00.
  - flush = 1 coincident with a load-use stall -> EX entry invalid the next cycle and stall = 1 for that cycle.
- Saturation: force 2^CNT_W + 3 stall cycles (CNT_W overridden to 4) -> stall_count holds at 15.
